serial_subtractor_2: RTL and testbench
======================================

Name: serial_subtractor_2

Overview:
- Digit-serial unsigned subtractor, 2 bits per clock, computing diff = a - b over WIDTH bits with a final borrow.
- Subtraction counterpart of the 2-bit adder slice in the floating-point multiplier datapath.
- Used for exponent bias removal and exponent comparison, where area matters more than latency.
- Start/done handshake; one subtraction in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits; must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when busy=0 or done=1
- a  input  WIDTH  minuend, captured on the accepting edge
- b  input  WIDTH  subtrahend, captured on the accepting edge
- busy  output  1  high while a subtraction is in progress (RUN state)
- done  output  1  single-cycle pulse; diff/borrow valid
- diff  output  WIDTH  (a - b) mod 2^WIDTH
- borrow  output  1  1 iff a < b (unsigned)

Behaviour:
- Reset: sampled at the clock edge; takes priority over everything, including mid-operation.
  - State -> IDLE.
  - busy=0, done=0, diff=0, borrow=0.
  - Internal operand, shift and count registers cleared.
  - Any in-flight subtraction is discarded; no done is produced for it.
- States:
  - IDLE: busy=0, done=0. start=1 -> RUN.
  - RUN: busy=1, done=0. Stays in RUN for exactly WIDTH/2 edges, then -> DONE.
  - DONE: busy=0, done=1 for one cycle. start=1 -> RUN (back-to-back); else -> IDLE.
- Accept edge (start=1 in IDLE or DONE):
  - latch a and b into shift registers;
  - internal borrow-in = 0;
  - digit count = 0.
  - diff and borrow keep their previous values until the new done.
- Each RUN edge processes one 2-bit digit, LSB digit first:
  - t = {a1,a0} - {b1,b0} - bin, computed as a 3-bit two's-complement value;
  - the low 2 bits of t shift into the top of the result register; operand registers shift right by 2;
  - bout = t[2]; bout is the borrow-in for the next digit;
  - count increments.
- Last-digit edge (count = WIDTH/2-1):
  - final result loads to diff;
  - final bout loads to borrow;
  - state -> DONE.
  - done is visible during the cycle after that edge.
- Latency: done is high exactly WIDTH/2 edges after the accepting edge. Back-to-back throughput is one result per WIDTH/2+1 cycles.
- start while in RUN is ignored: no restart, no queuing, and a/b are not re-sampled.
- diff and borrow hold their value after DONE until the next done overwrites them.
- Arithmetic:
  - purely unsigned; diff wraps modulo 2^WIDTH;
  - borrow is the only underflow indication;
  - a == b gives diff=0, borrow=0.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8, reset then idle: after rst high for 2 cycles, busy=0, done=0, diff=0x00, borrow=0. Holding start=0 keeps all outputs unchanged.
- Basic subtraction: a=0x5A, b=0x3C, start pulse at edge T0.
  - busy=1 after T0 through T4;
  - done=1 for exactly the cycle after T4;
  - diff=0x1E, borrow=0.
- Underflow: a=0x00, b=0x01 -> diff=0xFF, borrow=1. a=0x7F, b=0x80 -> diff=0xFF, borrow=1. a=0x80, b=0x80 -> diff=0x00, borrow=0.
- Back-to-back and ignored start:
  - start held high continuously with a=0xFF, b=0x01, then a=0x10, b=0x20;
  - done pulses every 5 cycles;
  - results are 0xFE/0, then 0xF0/1;
  - a/b changes while busy do not affect the in-flight result.
- Reset mid-operation: assert rst two edges after accepting a=0x5A, b=0x3C.
  - Required: IDLE, diff=0, borrow=0, no done pulse.
  - A subsequent start with a=0x03, b=0x01 returns diff=0x02, borrow=0.
- Exhaustive compare, WIDTH=4: all 256 (a,b) pairs run sequentially; diff and borrow match the reference model (a-b) mod 16 and (a<b) on every done.

Source files
------------

// File: rtl/serial_subtractor_2.sv
// Digit-serial unsigned subtractor: one 2-bit digit per clock, LSB digit first.
// Start/done handshake with one subtraction in flight; all outputs are registered.
module serial_subtractor_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d, busy_q, busy_d, done_q, done_d, borrow_q, borrow_d;
  logic [2:0]       t;
  logic [WIDTH-1:0] res_shift;
  logic             accept;

  // Next-state, datapath digit step and registered-output decode
  always_comb begin
    t         = {1'b0, a_q[1:0]} - {1'b0, b_q[1:0]} - {2'b00, bin_q};
    res_shift = WIDTH'({t[1:0], res_q} >> 2'd2);
    accept    = start && (state_q != RUN);
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      res_d   = {WIDTH{1'b0}};
      cnt_d   = {CW{1'b0}};
      bin_d   = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_d   = a_q >> 2'd2;
          b_d   = b_q >> 2'd2;
          res_d = res_shift;
          bin_d = t[2];
          cnt_d = cnt_q + CW'(1);
          // The last digit's borrow-out is the underflow flag of the whole subtraction
          if (cnt_q == LAST) begin
            state_d  = DONE;
            diff_d   = res_shift;
            borrow_d = t[2];
          end else begin
            state_d = RUN;
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      bin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor_2.sv
// Self-checking bench for serial_subtractor_2: WIDTH=8 scenarios plus an
// exhaustive WIDTH=4 sweep, with expected results queued when stimulus is driven.
module tb_serial_subtractor_2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done, borrow;
  logic [7:0] diff;

  logic       start4 = 1'b0;
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  typedef struct packed {
    logic [7:0] d;
    logic       bw;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   passed = 0;
  int   total = 0;

  serial_subtractor_2 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  serial_subtractor_2 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.d  = 8'((int'(x) - int'(y) + 256) % 256);
    e.bw = (x < y);
    return e;
  endfunction

  task automatic test_reset();
    logic [7:0] d0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0)
      $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, want 0 0 00 0", busy, done, diff, borrow);
    else passed++;
    d0 = diff;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== d0 || borrow !== 1'b0)
        $display("FAIL idle_hold: busy=%b done=%b diff=%h borrow=%b, want 0 0 %h 0", busy, done, diff, borrow, d0);
      else passed++;
    end
  endtask

  task automatic test_basic();
    exp_t e;
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    q8.push_back(model8(8'h5A, 8'h3C));
    step();
    start = 1'b0; a = 8'h00; b = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL basic_busy[%0d]: busy=%b done=%b, want 1 0", i, busy, done);
      else passed++;
      step();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || q8.size() == 0) begin
      $display("FAIL basic_done: done=%b busy=%b, want 1 0", done, busy);
    end else begin
      e = q8.pop_front();
      if (diff !== e.d || borrow !== e.bw || e.d !== 8'h1E)
        $display("FAIL basic_result: diff=%h borrow=%b, want %h %b", diff, borrow, e.d, e.bw);
      else passed++;
    end
    step();
    total++;
    if (done !== 1'b0 || diff !== 8'h1E || borrow !== 1'b0)
      $display("FAIL basic_hold: done=%b diff=%h borrow=%b, want 0 1e 0", done, diff, borrow);
    else passed++;
    q8.delete();
  endtask

  task automatic test_underflow();
    logic [7:0] ta[3] = '{8'h00, 8'h7F, 8'h80};
    logic [7:0] tb_[3] = '{8'h01, 8'h80, 8'h80};
    exp_t e;
    int   cyc;
    for (int k = 0; k < 3; k++) begin
      a = ta[k]; b = tb_[k]; start = 1'b1;
      q8.push_back(model8(ta[k], tb_[k]));
      step();
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
        step();
        cyc++;
      end
      total++;
      if (cyc >= 20 || q8.size() == 0) begin
        $display("FAIL underflow_timeout[%0d]: no done within 20 cycles", k);
      end else begin
        e = q8.pop_front();
        if (diff !== e.d || borrow !== e.bw || cyc != 4)
          $display("FAIL underflow[%0d]: diff=%h borrow=%b latency=%0d, want %h %b 4", k, diff, borrow, cyc, e.d, e.bw);
        else passed++;
      end
      step();
    end
    q8.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   first = -1, ndone = 0;
    a = 8'hFF; b = 8'h01; start = 1'b1;
    q8.push_back(model8(8'hFF, 8'h01));
    q8.push_back(model8(8'h10, 8'h20));
    step();
    for (int i = 1; i <= 14; i++) begin
      if (i == 1) begin a = 8'h10; b = 8'h20; end
      if (i == 6) begin start = 1'b0; a = 8'hAA; b = 8'h55; end
      if (done === 1'b1) begin
        ndone++;
        total++;
        if (q8.size() == 0) begin
          $display("FAIL b2b_extra_done: unexpected done at cycle %0d", i);
        end else begin
          e = q8.pop_front();
          if (diff !== e.d || borrow !== e.bw)
            $display("FAIL b2b_result[%0d]: diff=%h borrow=%b, want %h %b", ndone, diff, borrow, e.d, e.bw);
          else passed++;
        end
        if (first < 0) first = i;
        else begin
          total++;
          if (i - first != 5) $display("FAIL b2b_spacing: got %0d cycles, want 5", i - first);
          else passed++;
        end
      end
      step();
    end
    total++;
    if (ndone != 2) $display("FAIL b2b_count: got %0d dones, want 2", ndone);
    else passed++;
    q8.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   ndone = 0, cyc;
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0)
      $display("FAIL midrst_state: busy=%b done=%b diff=%h borrow=%b, want 0 0 00 0", busy, done, diff, borrow);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) ndone++;
      step();
    end
    total++;
    if (ndone != 0) $display("FAIL midrst_no_done: got %0d dones, want 0", ndone);
    else passed++;
    a = 8'h03; b = 8'h01; start = 1'b1;
    q8.push_back(model8(8'h03, 8'h01));
    step();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    total++;
    if (cyc >= 20 || q8.size() == 0) begin
      $display("FAIL midrst_timeout: no done within 20 cycles");
    end else begin
      e = q8.pop_front();
      if (diff !== e.d || borrow !== e.bw)
        $display("FAIL midrst_result: diff=%h borrow=%b, want %h %b", diff, borrow, e.d, e.bw);
      else passed++;
    end
    step();
  endtask

  task automatic test_exhaustive4();
    exp_t e;
    int   cyc, bad = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
        e.d  = 8'((x - y + 16) % 16);
        e.bw = (x < y);
        q4.push_back(e);
        step();
        start4 = 1'b0;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 10) begin
          step();
          cyc++;
        end
        total++;
        if (cyc >= 10 || q4.size() == 0) begin
          $display("FAIL exh4_timeout: a=%0d b=%0d", x, y);
        end else begin
          e = q4.pop_front();
          if (diff4 !== e.d[3:0] || borrow4 !== e.bw || cyc != 2) begin
            bad++;
            if (bad <= 10)
              $display("FAIL exh4: a=%0d b=%0d diff=%h borrow=%b latency=%0d, want %h %b 2", x, y, diff4, borrow4, cyc, e.d[3:0], e.bw);
          end else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
